// File: rtl/ins_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ins_prefetch_queue
// Purpose  : Instruction prefetch unit for the mcu51 CPU. Fetches code bytes
//            over the shared address/data bus, holds them in a DEPTH-entry
//            circular FIFO, and hands them to the decoder through a
//            valid/ready handshake. Each byte is tagged with its PC. A flush
//            discards buffered and in-flight bytes and restarts fetching at
//            flush_addr.
// Ports    : clk, reset (async, active-low)
//            addr_bus/read_en/PSEN/data_bus - code memory bus
//            flush/flush_addr               - restart request
//            ins_valid/ins_data/ins_pc/ins_ready - decoder handshake
//            level                          - occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module ins_prefetch_queue #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 4,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          addr_bus,
  output logic                       read_en,
  output logic                       PSEN,
  input  logic [DATA_W-1:0]          data_bus,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  output logic                       ins_valid,
  output logic [DATA_W-1:0]          ins_data,
  output logic [ADDR_W-1:0]          ins_pc,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int                 c_LVL_W   = $clog2(DEPTH+1);
  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);
  localparam logic [3:0]         c_WAIT    = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_wcnt;
  logic [3:0]           w_wcnt_nxt;

  logic [ADDR_W-1:0]    r_fetch_pc;
  logic [c_LVL_W-1:0]   r_level;
  logic [c_LVL_W-1:0]   w_level_nxt;
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [DATA_W-1:0]    r_data_mem [DEPTH];
  logic [ADDR_W-1:0]    r_pc_mem   [DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;

  assign w_valid = (r_level != '0);
  // The bus byte is captured on the last cycle of a fetch. Only one fetch is
  // ever outstanding and fetching stops when the queue fills, so a push never
  // lands on a full queue.
  assign w_push  = (r_state == ST_REQ) && (r_wcnt == c_WAIT);
  assign w_pop   = w_valid && ins_ready;

  always_comb begin
    w_level_nxt = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
  end

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    if (flush) begin
      w_state_nxt = ST_REQ;
      w_wcnt_nxt  = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Decided on the current level: a pop while full restarts the
          // fetch one edge later.
          if (r_level < c_DEPTH_L) begin
            w_state_nxt = ST_REQ;
            w_wcnt_nxt  = 4'd0;
          end
        end
        ST_REQ: begin
          if (w_push) begin
            w_wcnt_nxt  = 4'd0;
            w_state_nxt = (w_level_nxt < c_DEPTH_L) ? ST_REQ : ST_IDLE;
          end else begin
            w_wcnt_nxt  = r_wcnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage and fetch address
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_level    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data_mem[i] <= '0;
        r_pc_mem[i]   <= RESET_PC;
      end
    end else if (flush) begin
      // The in-flight byte is simply not captured.
      r_fetch_pc <= flush_addr;
      r_level    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_push) begin
        r_data_mem[r_tail] <= data_bus;
        r_pc_mem[r_tail]   <= r_fetch_pc;
        r_tail             <= r_tail + c_PTR_W'(1);
        r_fetch_pc         <= r_fetch_pc + ADDR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      r_level <= w_level_nxt;
    end
  end

  assign read_en   = (r_state == ST_REQ);
  assign PSEN      = ~read_en;
  assign addr_bus  = r_fetch_pc;
  assign ins_valid = w_valid;
  assign ins_data  = r_data_mem[r_head];
  assign ins_pc    = r_pc_mem[r_head];
  assign level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_ins_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_prefetch_queue
// Purpose  : Self-checking bench for ins_prefetch_queue. A queue-based model
//            tracks the expected decoder stream, fetch address and bus strobe
//            cycle by cycle under directed and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_prefetch_queue;

  localparam int          ADDR_W      = 16;
  localparam int          DATA_W      = 8;
  localparam int          DEPTH       = 4;
  localparam int          WAIT_CYCLES = 1;
  localparam logic [15:0] RESET_PC    = 16'h0000;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] addr_bus;
  logic              read_en;
  logic              PSEN;
  logic [DATA_W-1:0] data_bus;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready;
  logic [2:0]        level;

  int n_checks = 0;
  int n_errors = 0;

  ins_prefetch_queue #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .RESET_PC    (RESET_PC)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .addr_bus   (addr_bus),
    .read_en    (read_en),
    .PSEN       (PSEN),
    .data_bus   (data_bus),
    .flush      (flush),
    .flush_addr (flush_addr),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .ins_pc     (ins_pc),
    .ins_ready  (ins_ready),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code memory image
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    logic [7:0] h;
    case (a)
      16'h0000: h = 8'h04;
      16'h0001: h = 8'h0A;
      16'h0002: h = 8'h14;
      default:  h = a[7:0] * 8'd37 + a[15:8] * 8'd11 + 8'h5A;
    endcase
    return h;
  endfunction

  assign data_bus = mem_f(addr_bus);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: queue of tagged bytes, the address being fetched, whether
  // a fetch is in progress and how many of its cycles have elapsed.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [15:0] pc;
    logic [7:0]  d;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_pc;
  bit          m_fetch;
  int          m_elapsed;

  task automatic model_reset();
    m_q.delete();
    m_pc      = RESET_PC;
    m_fetch   = 1'b0;
    m_elapsed = 0;
  endtask

  task automatic model_edge(input bit rdy, input bit fl, input logic [15:0] fa);
    int sz;
    bit push;
    bit pop;
    sz = m_q.size();
    if (fl) begin
      m_q.delete();
      m_pc      = fa;
      m_fetch   = 1'b1;
      m_elapsed = 0;
    end else begin
      push = m_fetch && (m_elapsed == WAIT_CYCLES);
      pop  = (sz != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{pc: m_pc, d: mem_f(m_pc)});
        m_pc = m_pc + 16'd1;
      end
      if (m_fetch) begin
        if (push) begin
          m_fetch   = (m_q.size() < DEPTH);
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end else if (sz < DEPTH) begin
        m_fetch   = 1'b1;
        m_elapsed = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("read_en",   32'(read_en),   32'(m_fetch));
    check("psen",      32'(PSEN),      32'(!m_fetch));
    check("addr_bus",  32'(addr_bus),  32'(m_pc));
    check("ins_valid", 32'(ins_valid), 32'(m_q.size() != 0));
    check("level",     32'(level),     32'(m_q.size()));
    if (m_q.size() != 0) begin
      check("ins_pc",   32'(ins_pc),   32'(m_q[0].pc));
      check("ins_data", 32'(ins_data), 32'(m_q[0].d));
    end
  endtask

  // Called at a falling edge: checks, drives, advances one rising edge.
  task automatic step(input bit rdy, input bit fl, input logic [15:0] fa);
    compare_outputs();
    ins_ready  = rdy;
    flush      = fl;
    flush_addr = fa;
    model_edge(rdy, fl, fa);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_read_en"},   32'(read_en),   32'd0);
    check({tag, "_psen"},      32'(PSEN),      32'd1);
    check({tag, "_addr_bus"},  32'(addr_bus),  32'(RESET_PC));
    check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
    check({tag, "_ins_data"},  32'(ins_data),  32'd0);
    check({tag, "_ins_pc"},    32'(ins_pc),    32'(RESET_PC));
    check({tag, "_level"},     32'(level),     32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] fa;

    reset      = 1'b0;
    ins_ready  = 1'b0;
    flush      = 1'b0;
    flush_addr = '0;
    model_reset();

    // Reset held for 15 cycles
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    // Streaming from address 0 with the decoder always ready
    repeat (20) step(1'b1, 1'b0, 16'h0);

    // Back-pressure from a fresh start at 0
    step(1'b0, 1'b1, 16'h0000);
    repeat (10) step(1'b0, 1'b0, 16'h0);
    check("bp_level",   32'(level),    32'd4);
    check("bp_read_en", 32'(read_en),  32'd0);
    check("bp_addr",    32'(addr_bus), 32'h0004);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("bp_resume_read_en", 32'(read_en),  32'd1);
    check("bp_resume_addr",    32'(addr_bus), 32'h0004);
    repeat (6) step(1'b1, 1'b0, 16'h0);

    // Flush mid-fetch at level 3
    step(1'b0, 1'b1, 16'h0040);
    n = 0;
    while (m_q.size() != 3 && n < 40) begin
      step(1'b0, 1'b0, 16'h0);
      n++;
    end
    check("fl_pre_level", 32'(level), 32'd3);
    step(1'b1, 1'b1, 16'h0100);
    check("fl_level", 32'(level),     32'd0);
    check("fl_valid", 32'(ins_valid), 32'd0);
    check("fl_addr",  32'(addr_bus),  32'h0100);
    repeat (6) step(1'b0, 1'b0, 16'h0);
    check("fl_head_pc",   32'(ins_pc),   32'h0100);
    check("fl_head_data", 32'(ins_data), 32'(mem_f(16'h0100)));

    // Address wrap, preceded by a back-to-back flush (last address wins)
    step(1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'hFFFF);
    repeat (12) step(1'b1, 1'b0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit rdy;
      bit fl;
      rdy = ($urandom_range(0, 99) < ((i / 500) * 20 + 10));
      fl  = ($urandom_range(0, 99) < 4);
      fa  = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                        : 16'($urandom);
      step(rdy, fl, fa);
    end

    // Asynchronous reset during a fetch with two bytes queued
    step(1'b0, 1'b1, 16'h2000);
    n = 0;
    while (!(m_q.size() == 2 && m_fetch) && n < 40) begin
      step(1'b0, 1'b0, 16'h0);
      n++;
    end
    check("ar_pre_level",   32'(level),   32'd2);
    check("ar_pre_read_en", 32'(read_en), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("arst_now");
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("arst_hold");
    reset = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    check("ar_restart_read_en", 32'(read_en),  32'd1);
    check("ar_restart_addr",    32'(addr_bus), 32'(RESET_PC));

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3),
           16'($urandom));
    end
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ins_prefetch_queue.md
# ins_prefetch_queue

Parametrised instruction prefetch unit for the mcu51 CPU.
- Fetches program bytes from external/internal code memory over the shared address/data bus and buffers them in a DEPTH-entry FIFO.
- Presents them to the decoder through a valid/ready handshake, each byte tagged with its PC.
- On a taken branch, interrupt vector or reset it discards buffered and in-flight bytes and restarts fetching at a new address.
- Replaces the fixed one-byte-per-request fetch path between the bus and the decoder.

## Interface
- ADDR_W, 16: program address width.
- DATA_W, 8: code byte width.
- DEPTH, 4: queue entries; power of two, at least 2.
- WAIT_CYCLES, 1: extra bus cycles per read, 0..15; a fetch lasts WAIT_CYCLES+1 cycles.
- RESET_PC, 0: fetch address after reset.

- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_bus  out  ADDR_W  code fetch address.
- read_en  out  1  bus read strobe, high while a fetch is in flight.
- PSEN  out  1  program store enable, active-low; always equal to ~read_en.
- data_bus  in  DATA_W  code byte from memory; valid on the last cycle of a fetch.
- flush  in  1  restart request, single cycle.
- flush_addr  in  ADDR_W  new fetch address, sampled when flush=1.
- ins_valid  out  1  queue head holds a byte.
- ins_data  out  DATA_W  byte at the queue head.
- ins_pc  out  ADDR_W  address of ins_data.
- ins_ready  in  1  decoder accepts the head byte.
- level  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Fetch FSM has two states, IDLE and REQ, plus a wait counter wcnt (4 bits).
- IDLE:
  - read_en=0.
  - Moves to REQ, with wcnt cleared, when level<DEPTH.
- REQ:
  - read_en=1; addr_bus=fetch_pc.
  - wcnt increments each cycle until it equals WAIT_CYCLES.
  - On the edge ending that cycle, data_bus is pushed with tag fetch_pc, and fetch_pc is incremented.
  - Next state is REQ (wcnt cleared) if the post-push/post-pop level is below DEPTH; otherwise IDLE.
- Only one fetch is outstanding. A push therefore never meets a full queue.
- fetch_pc arithmetic is modulo 2^ADDR_W: address 2^ADDR_W-1 is followed by 0.
- Queue:
  - Circular buffer with head and tail pointers modulo DEPTH.
  - ins_valid = (level!=0); ins_data and ins_pc are the head entry.
  - Pop occurs when ins_valid && ins_ready.
  - Simultaneous push and pop leaves level unchanged.
- Flush (highest priority, overrides push, pop and FSM):
  - At the edge where flush=1: level←0 and pointers reset.
  - The in-flight byte is discarded; fetch_pc←flush_addr.
  - FSM←REQ with wcnt cleared.
  - ins_ready in the flush cycle has no effect.
- Consecutive flush cycles: the last flush_addr wins.

## Timing
- Reset values:
  - addr_bus=RESET_PC, read_en=0, PSEN=1.
  - ins_valid=0, ins_data=0, ins_pc=RESET_PC, level=0.
  - FSM=IDLE, fetch_pc=RESET_PC.
- After reset release: first edge moves IDLE→REQ, so read_en=1 in cycle 1.
- First byte reaches the head WAIT_CYCLES+1 cycles after read_en rises.
- Throughput: one byte per WAIT_CYCLES+1 cycles. read_en stays high continuously between fetches; addr_bus steps at each capture edge.
- Full queue: read_en falls in the cycle after the edge that filled it. A pop in IDLE restarts the fetch on the next edge.
- Flush: read_en stays 1 (or rises) in the next cycle with addr_bus=flush_addr. ins_valid=0 from the next cycle until the first post-flush capture.
- Reset asserted mid-fetch: all outputs return to reset values immediately (asynchronous); the partial fetch is dropped.
- All outputs are registered or decoded from registers only; no combinational path from ins_ready or flush to read_en/addr_bus.

## Test plan
- Reset: hold reset=0 for 15 cycles → read_en=0, PSEN=1, addr_bus=0000, ins_valid=0, level=0. Release → read_en=1 next cycle.
- Streaming, WAIT_CYCLES=1, ins_ready=1, memory returns 04,0A,14 at addresses 0,1,2 → decoder receives (pc0,04), (pc1,0A), (pc2,14) at 2-cycle spacing, level never exceeds 1.
- Back-pressure, DEPTH=4, ins_ready=0 → level reaches 4 after 8 fetch cycles, read_en=0 with addr_bus=0004. Raise ins_ready for one cycle → fetch of 0004 resumes.
- Flush mid-fetch, level=3, flush_addr=0x0100 → next cycle level=0, ins_valid=0, addr_bus=0100. Next head is (0100, mem[0100]).
- Wrap: flush_addr=0xFFFF → bytes tagged FFFF then 0000.
- Reset asserted during REQ with level=2 → outputs reset asynchronously. Fetch restarts at RESET_PC after release.
